// File: rtl/mux_ctrl_pkg.sv
// Shared types and select encodings for the round-robin mux arbiter.
// The select codes follow the tristate-buffer wiring of max_4to1, not binary order.
package mux_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // {I1,I0} codes for each mux input
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b00;
  localparam logic [1:0] SEL_D3 = 2'b11;
  localparam logic [1:0] SEL_D4 = 2'b10;

  function automatic logic [1:0] idx2sel(input logic [1:0] idx);
    logic [1:0] sel;
    case (idx)
      2'd0:    sel = SEL_D1;
      2'd1:    sel = SEL_D2;
      2'd2:    sel = SEL_D3;
      default: sel = SEL_D4;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: the scan starts just after `last`
// and wraps, so `last` itself gets the lowest priority.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // NOTE: every output gets a default before the loop; without it the
  // no-request path would hold its old value and infer a latch.
  always_comb begin
    valid = |req;
    idx   = last;
    cand  = last;
    // Walk from lowest to highest priority so the final hit is the winner.
    for (int k = 3; k >= 0; k--) begin
      cand = last + 2'(k) + 2'd1;
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that grants one of four requesters with a bounded burst
// and drives the max_4to1 select lines so the granted source reaches Q.
module mux_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       I0,
  output logic       I1,
  output logic       busy
);

  localparam logic [3:0] BURST = 4'(MAX_BURST);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic       hold;

  rr_pick4 u_pick (
    .req   (req),
    .last  (owner_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign hold = req[owner_q] && (cnt_q < BURST);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
          cnt_d   = 4'd1;
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = idx2sel(pick_idx);
        end
      end
      GRANT: begin
        if (hold) begin
          cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end else if (pick_valid) begin
          // Handover (or re-grant of a sole requester) with no idle cycle.
          owner_d = pick_idx;
          cnt_d   = 4'd1;
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = idx2sel(pick_idx);
        end else begin
          // Select stays parked on the last owner.
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd3;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= SEL_D1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt  = gnt_q;
  assign I0   = sel_q[0];
  assign I1   = sel_q[1];
  assign busy = |gnt_q;

endmodule
